// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA raster constants, counter type and timing FSM states
package vga_timing_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef logic [10:0] cnt_t;

    localparam int H800_SYNC = 120;
    localparam int H800_BP   = 64;
    localparam int H800_ACT  = 800;
    localparam int H800_FP   = 56;
    localparam int V800_SYNC = 6;
    localparam int V800_BP   = 23;
    localparam int V800_ACT  = 600;
    localparam int V800_FP   = 37;

    localparam int H640_SYNC = 96;
    localparam int H640_BP   = 48;
    localparam int H640_ACT  = 640;
    localparam int H640_FP   = 16;
    localparam int V640_SYNC = 2;
    localparam int V640_BP   = 33;
    localparam int V640_ACT  = 480;
    localparam int V640_FP   = 10;

    localparam int H_TOTAL     = H800_SYNC + H800_BP + H800_ACT + H800_FP;
    localparam int V_TOTAL     = V800_SYNC + V800_BP + V800_ACT + V800_FP;
    localparam int H_ACT_START = H800_SYNC + H800_BP;
    localparam int V_ACT_START = V800_SYNC + V800_BP;

    function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage sync shift register resetting to the inactive level
module vga_sync_delay #(
    parameter int   DEPTH = 1,
    parameter logic INIT  = 1'b0
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [DEPTH-1:0] sr_q, sr_d;
        always_comb begin
            sr_d = DEPTH'({sr_q, din});
        end
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) sr_q <= {DEPTH{INIT}};
            else        sr_q <= sr_d;
        end
        assign dout = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_timing_module.sv
// vga_sync_timing_module: VGA raster counters, run/drain FSM, active-area addresses and delayed syncs
module vga_sync_timing_module
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = H800_SYNC,
    parameter int   H_BP     = H800_BP,
    parameter int   H_ACT    = H800_ACT,
    parameter int   H_FP     = H800_FP,
    parameter int   V_SYNC   = V800_SYNC,
    parameter int   V_BP     = V800_BP,
    parameter int   V_ACT    = V800_ACT,
    parameter int   V_FP     = V800_FP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   SYNC_DLY = 1
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        En,
    output logic        Ready_Sig,
    output logic [10:0] Column_Addr_Sig,
    output logic [10:0] Row_Addr_Sig,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic        Frame_Start_Sig
);

    localparam cnt_t H_LAST     = cnt_t'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC);
    localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC);
    localparam cnt_t H_ACT_LO   = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t H_ACT_HI   = cnt_t'(H_SYNC + H_BP + H_ACT);
    localparam cnt_t V_ACT_LO   = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t V_ACT_HI   = cnt_t'(V_SYNC + V_BP + V_ACT);

    state_t state_q, state_d;
    cnt_t   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    cnt_t   col_q, col_d, row_q, row_d;
    logic   ready_q, ready_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic   running, line_end, frame_end, active;

    always_comb begin
        running   = state_q != IDLE;
        line_end  = hcnt_q == H_LAST;
        frame_end = line_end && (vcnt_q == V_LAST);
        // DRAIN holds off IDLE until the frame in flight has fully completed
        state_d   = En ? RUN
                  : (state_q == RUN) ? DRAIN
                  : (state_q == DRAIN && !frame_end) ? DRAIN
                  : IDLE;
        hcnt_d    = (!running || line_end) ? '0 : hcnt_q + cnt_t'(1);
        vcnt_d    = !running ? '0
                  : !line_end ? vcnt_q
                  : (vcnt_q == V_LAST) ? '0
                  : vcnt_q + cnt_t'(1);
        active    = running && in_window(hcnt_q, H_ACT_LO, H_ACT_HI) && in_window(vcnt_q, V_ACT_LO, V_ACT_HI);
        ready_d   = active;
        col_d     = active ? hcnt_q - H_ACT_LO : '0;
        row_d     = active ? vcnt_q - V_ACT_LO : '0;
        hs_d      = (running && hcnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
        vs_d      = (running && vcnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
        fs_d      = (state_d != IDLE) && (hcnt_d == '0) && (vcnt_d == '0);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            ready_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            ready_q <= ready_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    // extra stages line the syncs up with the colour block's registered pixel
    vga_sync_delay #(.DEPTH(SYNC_DLY), .INIT(~HS_POL)) u_hs_dly (
        .CLK  (CLK),
        .RST_n(RST_n),
        .din  (hs_q),
        .dout (HSYNC_Sig)
    );

    vga_sync_delay #(.DEPTH(SYNC_DLY), .INIT(~VS_POL)) u_vs_dly (
        .CLK  (CLK),
        .RST_n(RST_n),
        .din  (vs_q),
        .dout (VSYNC_Sig)
    );

    assign Ready_Sig       = ready_q;
    assign Column_Addr_Sig = col_q;
    assign Row_Addr_Sig    = row_q;
    assign Frame_Start_Sig = fs_q;

endmodule

// File: tb/tb_vga_sync_timing_module.sv
// tb_vga_sync_timing_module: directed checks of raster timing, run/drain/idle control and async reset
module tb_vga_sync_timing_module;

    localparam int HS = 4, HB = 3, HA = 10, HF = 2;
    localparam int VS = 2, VB = 2, VA = 5, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int HAS = HS + HB;
    localparam int VAS = VS + VB;
    localparam int BIG = 1 << 30;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        En = 1'b0;
    logic        Ready_Sig, HSYNC_Sig, VSYNC_Sig, Frame_Start_Sig;
    logic [10:0] Column_Addr_Sig, Row_Addr_Sig;

    int checks = 0;
    int failures = 0;
    int p = -100000;
    int stop = BIG;
    int rc;

    always #5 CLK = ~CLK;

    vga_sync_timing_module #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .HS_POL(1'b1), .VS_POL(1'b1), .SYNC_DLY(1)
    ) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .En             (En),
        .Ready_Sig      (Ready_Sig),
        .Column_Addr_Sig(Column_Addr_Sig),
        .Row_Addr_Sig   (Row_Addr_Sig),
        .HSYNC_Sig      (HSYNC_Sig),
        .VSYNC_Sig      (VSYNC_Sig),
        .Frame_Start_Sig(Frame_Start_Sig)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (p=%0d)", tag, obs, exp, p);
        end
    endtask

    // p is the raster position held in the counters; Ready lags it by 1, syncs by 2
    task automatic check_all();
        int q, h, v, ec, erw;
        logic er, ehs, evs, efs;
        q = p - 1; er = 1'b0; ec = 0; erw = 0;
        if (q >= 0 && q < stop) begin
            h = q % HT;
            v = (q / HT) % VT;
            if (h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA) begin
                er = 1'b1; ec = h - HAS; erw = v - VAS;
            end
        end
        q = p - 2; ehs = 1'b0; evs = 1'b0;
        if (q >= 0 && q < stop) begin
            ehs = (q % HT) < HS;
            evs = ((q / HT) % VT) < VS;
        end
        efs = (p >= 0) && (p < stop) && (p % FT == 0);
        chk("ready", 32'(Ready_Sig), 32'(er));
        chk("column", 32'(Column_Addr_Sig), 32'(ec));
        chk("row", 32'(Row_Addr_Sig), 32'(erw));
        chk("hsync", 32'(HSYNC_Sig), 32'(ehs));
        chk("vsync", 32'(VSYNC_Sig), 32'(evs));
        chk("frame_start", 32'(Frame_Start_Sig), 32'(efs));
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge CLK);
            p++;
            check_all();
        end
    endtask

    task automatic adv_to(input int target);
        while (p < target) adv(1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(Ready_Sig), 32'd0);
        chk({tag, "_column"}, 32'(Column_Addr_Sig), 32'd0);
        chk({tag, "_row"}, 32'(Row_Addr_Sig), 32'd0);
        chk({tag, "_hsync"}, 32'(HSYNC_Sig), 32'd0);
        chk({tag, "_vsync"}, 32'(VSYNC_Sig), 32'd0);
        chk({tag, "_frame_start"}, 32'(Frame_Start_Sig), 32'd0);
    endtask

    initial begin
        @(negedge CLK);
        chk_reset("por");
        RST_n = 1'b1;
        adv(3);

        // two full frames from a clean start
        En = 1'b1;
        p = -1;
        for (int f = 0; f < 2; f++) begin
            rc = 0;
            repeat (FT) begin
                adv(1);
                if (Ready_Sig) rc++;
                if (p == 2)   chk("hs_first_active", 32'(HSYNC_Sig), 32'd1);
                if (p == 6)   chk("hs_fall", 32'(HSYNC_Sig), 32'd0);
                if (p == 21)  chk("hs_next_line", 32'(HSYNC_Sig), 32'd1);
                if (p == 39)  chk("vs_last_active", 32'(VSYNC_Sig), 32'd1);
                if (p == 40)  chk("vs_fall", 32'(VSYNC_Sig), 32'd0);
                if (p == 84) begin
                    chk("first_ready", 32'(Ready_Sig), 32'd1);
                    chk("first_col", 32'(Column_Addr_Sig), 32'd0);
                    chk("first_row", 32'(Row_Addr_Sig), 32'd0);
                end
                if (p == 169) begin
                    chk("last_col", 32'(Column_Addr_Sig), 32'd9);
                    chk("last_row", 32'(Row_Addr_Sig), 32'd4);
                end
                if (p == 170) chk("after_last_ready", 32'(Ready_Sig), 32'd0);
            end
            chk("ready_count", 32'(rc), 32'd50);
        end

        // drop En mid-frame: frame completes, then IDLE
        adv_to(475);
        En = 1'b0;
        stop = 570;
        adv_to(600);
        chk("idle_ready", 32'(Ready_Sig), 32'd0);

        // restart, then toggle En inside DRAIN including across the frame boundary
        En = 1'b1;
        p = -1;
        stop = BIG;
        adv(1);
        chk("fs_restart", 32'(Frame_Start_Sig), 32'd1);
        adv_to(50);
        En = 1'b0;
        adv(3);
        En = 1'b1;
        adv_to(185);
        En = 1'b0;
        adv_to(189);
        En = 1'b1;
        adv_to(296);
        chk("pre_reset_ready", 32'(Ready_Sig), 32'd1);
        chk("pre_reset_col", 32'(Column_Addr_Sig), 32'd3);
        chk("pre_reset_row", 32'(Row_Addr_Sig), 32'd1);

        // asynchronous reset mid-frame
        RST_n = 1'b0;
        #1;
        chk_reset("async_rst");
        p = -100000;
        adv(2);
        RST_n = 1'b1;
        p = -1;
        adv(1);
        chk("fs_after_reset", 32'(Frame_Start_Sig), 32'd1);
        adv(FT + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
